mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one memory_controller port (32x8 single-port RAM behind it) among NUM_REQ
//  requesters (FSM datapaths such as memset). One access is issued per cycle; read data returns tagged to its issuer.
//  Optional short lock holds the port for read-modify-write sequences. Sits between the requesters and memory_controller.
// PARAMETERS
//  NUM_REQ   2   number of requesters (2..8)
//  ID_W      1   index width; must satisfy 2**ID_W >= NUM_REQ
//  ADDR_W    32  address width (= `MEMORY_CONTROLLER_ADDR_SIZE)
//  DATA_W    32  data width (= `MEMORY_CONTROLLER_DATA_SIZE)
//  LOCK_MAX  4   max consecutive grants to one locked requester (>=1)
// PORTS
//  clk                            in   1               single clock, rising edge
//  reset                          in   1               synchronous, active-high
//  req                            in   NUM_REQ         request per requester; hold with cmd fields until gnt
//  lock                           in   NUM_REQ         keep port after this grant (RMW)
//  we                             in   NUM_REQ         1 = write, 0 = read
//  addr                           in   NUM_REQ*ADDR_W  flat; requester i at [i*ADDR_W +: ADDR_W]
//  wdata                          in   NUM_REQ*DATA_W  flat; same packing
//  gnt                            out  NUM_REQ         one-hot (or 0) accept, combinational in request cycle
//  rvalid                         out  NUM_REQ         one-hot read-data strobe
//  rdata                          out  DATA_W          shared read data, valid with rvalid
//  busy                           out  1               any access in flight or locked
//  memory_controller_address      out  ADDR_W          registered to memory_controller
//  memory_controller_write_enable out  1               registered
//  memory_controller_in           out  DATA_W          registered
//  memory_controller_out          in   DATA_W          from memory_controller
// BEHAVIOUR
//  - Reset: gnt=0, rvalid=0, rdata=0, busy=0, mc address/in=0, write_enable=0, rr pointer=0, state ARB, lock_cnt=0.
//  - Arbitration (state ARB): winner = first i with req[i] scanning from pointer upward mod NUM_REQ; gnt[winner]=1 same cycle.
//    After a grant, pointer <= winner+1 (wrap NUM_REQ-1 -> 0). No req: pointer unchanged, gnt=0.
//  - Issue: on grant edge, mc outputs <= winner's addr/we/wdata. Non-grant cycle: write_enable <= 0 (address/in hold).
//  - Read latency: grant in cycle T -> mc cmd in T+1 -> RAM samples end of T+1 -> rvalid[id]=1, rdata=memory_controller_out in T+2.
//    Tracking is a 2-stage shift register of {is_read, id}; back-to-back reads give rvalid every cycle, in grant order.
//  - Writes: no rvalid; write complete at end of T+1. Read after write, same addr, granted T+1 returns new data.
//  - Lock FSM: ARB -> LOCKED when granted requester has lock=1 and LOCK_MAX>1; owner saved, lock_cnt=1.
//    LOCKED: only owner may be granted (others gnt=0); each owner grant increments lock_cnt. Exit to ARB when owner drops lock,
//    or when lock_cnt reaches LOCK_MAX (forced release, that grant is still issued). Pointer <= owner+1 on exit.
//    Owner with lock=1 but req=0 keeps port idle (write_enable 0); idle cycles do not count toward LOCK_MAX.
//  - busy = (state==LOCKED) | any stage of read-tracking pipe valid | write issue stage valid.
//  - Simultaneous: all req high -> strict rotation 0,1,..,NUM_REQ-1; max wait NUM_REQ-1 grants (+LOCK_MAX-1 if locked).
//  - Reset mid-operation: in-flight reads discarded (no rvalid), lock released, pointer to 0; RAM contents untouched.
//  - Address/data passed unmodified; memory_controller uses addr[4:0], data[7:0].
// STRUCTURE
//  - Widths/defaults come from the shared memory_controller defines header (`MEMORY_CONTROLLER_ADDR_SIZE, _DATA_SIZE);
//    FSM state encodings ARB/LOCKED as localparams in this file.
//  - One sub-module: rr_priority_select (req, pointer -> one-hot grant + index), combinational, reusable.
// TESTING
//  - Reset: hold reset 3 cycles with req=all 1 -> gnt=0, rvalid=0, write_enable=0 throughout; first gnt the cycle after reset drops.
//  - Single: req0 write addr 5 data 0xA5, then read addr 5 -> rvalid[0] two cycles after read gnt, rdata[7:0]=0xA5.
//  - Fairness: NUM_REQ=2, req=2'b11 held 6 cycles -> gnt sequence 01,10,01,10,01,10.
//  - Pipelined reads: r0 addr 1, r1 addr 2 back-to-back (RAM 0x11,0x22) -> rvalid 01 then 10 consecutive, rdata 0x11 then 0x22.
//  - Lock: req0+lock0 held, req1 held, LOCK_MAX=4 -> four gnt[0], then gnt[1]; lock0 dropped after 2 -> gnt[1] next cycle.
//  - Reset mid-read: reset asserted in cycle T+1 after read grant -> no rvalid in T+2, pointer=0, busy=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults, FSM encoding and index helper for the memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned MC_ADDR_SIZE = 32;
  localparam int unsigned MC_DATA_SIZE = 32;

  localparam logic ST_ARB    = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    ARB    = ST_ARB,
    LOCKED = ST_LOCKED
  } arb_state_e;

  // Round-robin successor of idx among n requesters.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first asserted request at or above pointer, wrapping.
module rr_priority_select #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  logic        found;
  int unsigned pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(pointer) + k) % N;
      if (!found && req[SW'(pos)]) begin
        found            = 1'b1;
        grant[SW'(pos)]  = 1'b1;
        index            = IW'(pos);
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory_controller port among NUM_REQ requesters,
// with read-data return tagged to the issuer and a bounded lock for RMW sequences.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ID_W     = 1,
  parameter int unsigned ADDR_W   = MC_ADDR_SIZE,
  parameter int unsigned DATA_W   = MC_DATA_SIZE,
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         memory_controller_address,
  output logic                      memory_controller_write_enable,
  output logic [DATA_W-1:0]         memory_controller_in,
  input  logic [DATA_W-1:0]         memory_controller_out
);
  localparam int unsigned SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    owner;
  logic [CNT_W-1:0]   lock_cnt;
  logic [NUM_REQ-1:0] sel_grant;
  logic [ID_W-1:0]    sel_idx;
  logic               sel_valid;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               win_we;
  logic               win_lock;
  logic               owner_lock;
  logic               enter_lock;
  logic               exit_lock;
  logic               s0_valid;
  logic               s0_read;
  logic [ID_W-1:0]    s0_id;
  logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_a [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i]  = addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = wdata[i*DATA_W +: DATA_W];
  end

  rr_priority_select #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr (
    .req     (req),
    .pointer (ptr),
    .grant   (sel_grant),
    .index   (sel_idx),
    .valid   (sel_valid)
  );

  // While locked only the owner can win; an idle owner keeps the port empty.
  always_comb begin
    gnt       = '0;
    win_valid = 1'b0;
    win_id    = sel_idx;
    if (!reset) begin
      if (state == ARB) begin
        gnt       = sel_grant;
        win_valid = sel_valid;
      end else if (req[SEL_W'(owner)]) begin
        gnt[SEL_W'(owner)] = 1'b1;
        win_valid          = 1'b1;
        win_id             = owner;
      end
    end
  end

  assign win_we     = we[SEL_W'(win_id)];
  assign win_lock   = lock[SEL_W'(win_id)];
  assign owner_lock = lock[SEL_W'(owner)];
  assign enter_lock = (state == ARB) && win_valid && win_lock && (LOCK_MAX > 1);
  assign exit_lock  = (state == LOCKED) &&
                      (!owner_lock || (win_valid && (32'(lock_cnt) + 1 == LOCK_MAX)));

  assign rdata = (|rvalid) ? memory_controller_out : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                          <= ARB;
      ptr                            <= '0;
      owner                          <= '0;
      lock_cnt                       <= '0;
      s0_valid                       <= 1'b0;
      s0_read                        <= 1'b0;
      s0_id                          <= '0;
      rvalid                         <= '0;
      busy                           <= 1'b0;
      memory_controller_address      <= '0;
      memory_controller_write_enable <= 1'b0;
      memory_controller_in           <= '0;
    end else begin
      // Issue stage then response stage; RAM output lines up with the second.
      s0_valid <= win_valid;
      s0_read  <= win_valid && !win_we;
      s0_id    <= win_id;
      rvalid   <= (s0_valid && s0_read) ? (NUM_REQ'(1'b1) << s0_id) : '0;
      busy     <= enter_lock || ((state == LOCKED) && !exit_lock) || win_valid ||
                  (s0_valid && s0_read);

      if (win_valid) begin
        memory_controller_address      <= addr_a[SEL_W'(win_id)];
        memory_controller_write_enable <= win_we;
        memory_controller_in           <= wdata_a[SEL_W'(win_id)];
      end else begin
        memory_controller_write_enable <= 1'b0;
      end

      case (state)
        ARB: begin
          if (win_valid) begin
            ptr <= ID_W'(next_idx(32'(win_id), NUM_REQ));
            if (enter_lock) begin
              state    <= LOCKED;
              owner    <= win_id;
              lock_cnt <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          if (exit_lock) begin
            state    <= ARB;
            ptr      <= ID_W'(next_idx(32'(owner), NUM_REQ));
            lock_cnt <= '0;
          end else if (win_valid) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference model and a 32x8 RAM stand-in.
module tb_mem_port_arbiter;
  localparam int unsigned NR    = 2;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LMAX  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR-1:0] lock = '0;
  logic [NR-1:0] we = '0;
  logic [NR*AW-1:0] addr = '0;
  logic [NR*DW-1:0] wdata = '0;
  logic [NR-1:0] gnt;
  logic [NR-1:0] rvalid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [AW-1:0] mc_addr;
  logic          mc_we;
  logic [DW-1:0] mc_in;
  logic [DW-1:0] mc_out = '0;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .NUM_REQ(NR), .ID_W(1), .ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LMAX)
  ) dut (
    .clk                            (clk),
    .reset                          (reset),
    .req                            (req),
    .lock                           (lock),
    .we                             (we),
    .addr                           (addr),
    .wdata                          (wdata),
    .gnt                            (gnt),
    .rvalid                         (rvalid),
    .rdata                          (rdata),
    .busy                           (busy),
    .memory_controller_address      (mc_addr),
    .memory_controller_write_enable (mc_we),
    .memory_controller_in           (mc_in),
    .memory_controller_out          (mc_out)
  );

  always #5 clk = ~clk;

  // Stand-in for memory_controller: registered read, write at the same edge.
  logic [7:0] ram [32];
  always @(posedge clk) begin
    if (mc_we) ram[mc_addr[4:0]] <= mc_in[7:0];
    mc_out <= {24'h0, ram[mc_addr[4:0]]};
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  // Reference model: access-level view of the shared port.
  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
  } rd_t;

  logic [7:0] gold [32];
  rd_t        rdq [$];
  int         m_ptr = 0;
  int         m_owner = -1;
  int         m_cnt = 0;
  int         m_cyc = 0;
  int         m_last_gnt = -10;
  bit         m_init = 0;
  logic [31:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [31:0] m_in = '0;

  function automatic int pick();
    if (reset) return -1;
    if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < int'(NR); k++) begin
      int i;
      i = (m_ptr + k) % int'(NR);
      if (req[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    int a;
    rd_t r;
    if (reset) begin
      m_init = 1;
      m_ptr = 0; m_owner = -1; m_cnt = 0; m_last_gnt = -10;
      m_addr = '0; m_we = 1'b0; m_in = '0;
      rdq.delete();
    end else begin
      w = pick();
      if (w >= 0) begin
        m_last_gnt = m_cyc;
        m_addr = addr[w*32 +: 32];
        m_we   = we[w];
        m_in   = wdata[w*32 +: 32];
        a = int'(m_addr[4:0]);
        if (we[w]) gold[a] = m_in[7:0];
        else begin
          r.due = m_cyc + 2; r.id = w; r.data = gold[a];
          rdq.push_back(r);
        end
        if (m_owner < 0) begin
          m_ptr = (w + 1) % int'(NR);
          if (lock[w] && LMAX > 1) begin m_owner = w; m_cnt = 1; end
        end else begin
          m_cnt++;
          if (!lock[w] || m_cnt == int'(LMAX)) begin
            m_ptr = (m_owner + 1) % int'(NR);
            m_owner = -1;
          end
        end
      end else begin
        m_we = 1'b0;
        if (m_owner >= 0 && !lock[m_owner]) begin
          m_ptr = (m_owner + 1) % int'(NR);
          m_owner = -1;
        end
      end
      if (rdq.size() > 0 && rdq[0].due == m_cyc) void'(rdq.pop_front());
    end
    m_cyc++;
  end

  always @(negedge clk) begin
    int w;
    logic [NR-1:0] eg;
    logic [NR-1:0] erv;
    logic eb;
    if (m_init) begin
      w = pick();
      eg = '0;
      if (w >= 0) eg = NR'(1) << w;
      erv = '0;
      if (rdq.size() > 0 && rdq[0].due == m_cyc) erv = NR'(1) << rdq[0].id;
      eb = (m_owner >= 0) || (m_last_gnt == m_cyc - 1) || (erv != '0);
      chk("gnt", 32'(gnt), 32'(eg));
      chk("rvalid", 32'(rvalid), 32'(erv));
      if (erv != '0) chk("rdata", rdata, {24'h0, rdq[0].data});
      chk("busy", 32'(busy), 32'(eb));
      chk("mc_we", 32'(mc_we), 32'(m_we));
      chk("mc_addr", mc_addr, m_addr);
      chk("mc_in", mc_in, m_in);
    end
  end

  task automatic set_req(input int i, input logic r, input logic l, input logic w,
                         input logic [7:0] a, input logic [7:0] d);
    req[i] = r; lock[i] = l; we[i] = w;
    addr[i*32 +: 32]  = {24'h0, a};
    wdata[i*32 +: 32] = {24'h0, d};
  endtask

  task automatic idle();
    set_req(0, 0, 0, 0, 8'h0, 8'h0);
    set_req(1, 0, 0, 0, 8'h0, 8'h0);
  endtask

  task automatic cyc(output logic [NR-1:0] g, output logic [NR-1:0] rv,
                     output logic [31:0] rd, output logic b);
    @(negedge clk);
    g = gnt; rv = rvalid; rd = rdata; b = busy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [NR-1:0] g;
    logic [NR-1:0] rv;
    logic [31:0]   rd;
    logic          b;
    logic [NR-1:0] fair_exp [6];
    logic [NR-1:0] lock_exp [5];
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    lock_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    for (int i = 0; i < 32; i++) begin ram[i] = 8'h0; gold[i] = 8'h0; end

    // Reset held with every requester active.
    set_req(0, 1, 0, 1, 8'd1, 8'h11);
    set_req(1, 1, 0, 1, 8'd2, 8'h22);
    repeat (3) begin
      cyc(g, rv, rd, b);
      chk("reset_gnt", 32'(g), 32'h0);
      chk("reset_rvalid", 32'(rv), 32'h0);
    end
    reset = 1'b0;
    cyc(g, rv, rd, b);
    chk("first_gnt", 32'(g), 32'h1);
    set_req(0, 0, 0, 0, 8'h0, 8'h0);
    cyc(g, rv, rd, b);
    chk("second_gnt", 32'(g), 32'h2);
    idle();
    repeat (2) cyc(g, rv, rd, b);

    // Write then read-after-write at the same address.
    set_req(0, 1, 0, 1, 8'd5, 8'hA5);
    cyc(g, rv, rd, b);
    chk("single_wr_gnt", 32'(g), 32'h1);
    set_req(0, 1, 0, 0, 8'd5, 8'h00);
    cyc(g, rv, rd, b);
    chk("single_rd_gnt", 32'(g), 32'h1);
    idle();
    cyc(g, rv, rd, b);
    chk("single_rv_early", 32'(rv), 32'h0);
    cyc(g, rv, rd, b);
    chk("single_rvalid", 32'(rv), 32'h1);
    chk("single_rdata", rd, 32'hA5);

    // Back-to-back reads from different requesters.
    set_req(0, 1, 0, 0, 8'd1, 8'h00);
    cyc(g, rv, rd, b);
    set_req(0, 0, 0, 0, 8'h0, 8'h0);
    set_req(1, 1, 0, 0, 8'd2, 8'h00);
    cyc(g, rv, rd, b);
    idle();
    cyc(g, rv, rd, b);
    chk("pipe_rv0", 32'(rv), 32'h1);
    chk("pipe_rd0", rd, 32'h11);
    cyc(g, rv, rd, b);
    chk("pipe_rv1", 32'(rv), 32'h2);
    chk("pipe_rd1", rd, 32'h22);
    cyc(g, rv, rd, b);

    // Both requesters held: strict alternation.
    set_req(0, 1, 0, 0, 8'd1, 8'h00);
    set_req(1, 1, 0, 0, 8'd2, 8'h00);
    for (int i = 0; i < 6; i++) begin
      cyc(g, rv, rd, b);
      chk("fair_gnt", 32'(g), 32'(fair_exp[i]));
    end
    idle();
    repeat (3) cyc(g, rv, rd, b);

    // Lock held past LOCK_MAX: forced release after four grants.
    set_req(0, 1, 1, 0, 8'd3, 8'h00);
    set_req(1, 1, 0, 0, 8'd4, 8'h00);
    for (int i = 0; i < 5; i++) begin
      cyc(g, rv, rd, b);
      chk("lockmax_gnt", 32'(g), 32'(lock_exp[i]));
    end
    idle();
    repeat (3) cyc(g, rv, rd, b);

    // RMW: locked read, idle owner, unlocked write, then the other requester.
    set_req(0, 1, 1, 0, 8'd7, 8'h00);
    set_req(1, 1, 0, 0, 8'd4, 8'h00);
    cyc(g, rv, rd, b);
    chk("rmw_rd_gnt", 32'(g), 32'h1);
    set_req(0, 0, 1, 0, 8'd7, 8'h00);
    cyc(g, rv, rd, b);
    chk("rmw_idle_gnt", 32'(g), 32'h0);
    chk("rmw_idle_busy", 32'(b), 32'h1);
    set_req(0, 1, 0, 1, 8'd7, 8'h5A);
    cyc(g, rv, rd, b);
    chk("rmw_wr_gnt", 32'(g), 32'h1);
    set_req(0, 0, 0, 0, 8'h0, 8'h0);
    cyc(g, rv, rd, b);
    chk("rmw_other_gnt", 32'(g), 32'h2);
    idle();
    repeat (3) cyc(g, rv, rd, b);

    // Reset the cycle after a read grant.
    set_req(0, 1, 0, 0, 8'd2, 8'h00);
    cyc(g, rv, rd, b);
    chk("mid_rd_gnt", 32'(g), 32'h1);
    idle();
    reset = 1'b1;
    cyc(g, rv, rd, b);
    reset = 1'b0;
    set_req(0, 1, 0, 0, 8'd1, 8'h00);
    set_req(1, 1, 0, 0, 8'd2, 8'h00);
    cyc(g, rv, rd, b);
    chk("mid_rst_rvalid", 32'(rv), 32'h0);
    chk("mid_rst_busy", 32'(b), 32'h0);
    chk("mid_rst_ptr_gnt", 32'(g), 32'h1);
    idle();
    repeat (4) cyc(g, rv, rd, b);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
